// File: rtl/time_of_day_counter_if.sv
// Bus between the MSF decoder / second counter and the time-of-day counter.
// The master drives strobes and load data; the slave returns the BCD time.
interface time_of_day_counter_if;
  logic       second_inc_i;
  logic       load_i;
  logic [5:0] load_hh_i;
  logic [6:0] load_mm_i;
  logic       leap_sec_i;
  logic [5:0] hours_o;
  logic [6:0] minutes_o;
  logic [6:0] seconds_o;
  logic       minute_inc_o;
  logic       day_inc_o;
  logic       load_err_o;

  modport master (
    output second_inc_i, load_i, load_hh_i, load_mm_i, leap_sec_i,
    input  hours_o, minutes_o, seconds_o, minute_inc_o, day_inc_o, load_err_o
  );

  modport slave (
    input  second_inc_i, load_i, load_hh_i, load_mm_i, leap_sec_i,
    output hours_o, minutes_o, seconds_o, minute_inc_o, day_inc_o, load_err_o
  );
endinterface

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time of day (hh:mm:ss) advanced by a 1 Hz strobe, with leap-second
// insertion, decoder time load and registered minute/day rollover strobes.
module time_of_day_counter #(
  parameter logic [5:0] RESET_HH = 6'h00,
  parameter logic [6:0] RESET_MM = 7'h00
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  time_of_day_counter_if.slave bus
);

  localparam int unsigned HH_W = 6;
  localparam int unsigned MS_W = 7;

  logic [HH_W-1:0] hh_q, hh_d;
  logic [MS_W-1:0] mm_q, mm_d;
  logic [MS_W-1:0] ss_q, ss_d;
  logic            minute_inc_q, minute_inc_d;
  logic            day_inc_q, day_inc_d;
  logic            load_err_q, load_err_d;
  logic            load_valid;

  // Per-digit BCD increment; the caller handles the wrap of the tens digit.
  function automatic logic [MS_W-1:0] inc_bcd7(input logic [MS_W-1:0] v);
    if (v[3:0] == 4'd9) return {v[6:4] + 3'd1, 4'd0};
    else                return {v[6:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [HH_W-1:0] inc_bcd6(input logic [HH_W-1:0] v);
    if (v[3:0] == 4'd9) return {v[5:4] + 2'd1, 4'd0};
    else                return {v[5:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    load_valid = (bus.load_mm_i[6:4] <= 3'd5) && (bus.load_mm_i[3:0] <= 4'd9) &&
                 (bus.load_hh_i[3:0] <= 4'd9) &&
                 ((bus.load_hh_i[5:4] < 2'd2) ||
                  ((bus.load_hh_i[5:4] == 2'd2) && (bus.load_hh_i[3:0] <= 4'd3)));
  end

  // Next-state: a valid load wins; otherwise the second strobe advances the clock.
  always_comb begin
    hh_d         = hh_q;
    mm_d         = mm_q;
    ss_d         = ss_q;
    minute_inc_d = 1'b0;
    day_inc_d    = 1'b0;
    load_err_d   = 1'b0;

    if (bus.load_i && load_valid) begin
      hh_d = bus.load_hh_i;
      mm_d = bus.load_mm_i;
      ss_d = 7'h00;
    end else begin
      load_err_d = bus.load_i;
      if (bus.second_inc_i) begin
        if ((ss_q == 7'h60) || ((ss_q == 7'h59) && !bus.leap_sec_i)) begin
          ss_d         = 7'h00;
          minute_inc_d = 1'b1;
          if (mm_q == 7'h59) begin
            mm_d = 7'h00;
            if (hh_q == 6'h23) begin
              hh_d      = 6'h00;
              day_inc_d = 1'b1;
            end else begin
              hh_d = inc_bcd6(hh_q);
            end
          end else begin
            mm_d = inc_bcd7(mm_q);
          end
        end else if (ss_q == 7'h59) begin
          ss_d = 7'h60;
        end else begin
          ss_d = inc_bcd7(ss_q);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hh_q         <= RESET_HH;
      mm_q         <= RESET_MM;
      ss_q         <= 7'h00;
      minute_inc_q <= 1'b0;
      day_inc_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      hh_q         <= hh_d;
      mm_q         <= mm_d;
      ss_q         <= ss_d;
      minute_inc_q <= minute_inc_d;
      day_inc_q    <= day_inc_d;
      load_err_q   <= load_err_d;
    end
  end

  assign bus.hours_o      = hh_q;
  assign bus.minutes_o    = mm_q;
  assign bus.seconds_o    = ss_q;
  assign bus.minute_inc_o = minute_inc_q;
  assign bus.day_inc_o    = day_inc_q;
  assign bus.load_err_o   = load_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: hand sequences for long rollovers,
// then a vector table for boundaries, leap seconds, loads and collisions.
module tb_time_of_day_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  time_of_day_counter_if bus ();

  time_of_day_counter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pre;
    bit         rst;
    bit         load;
    logic [5:0] hh;
    logic [6:0] mm;
    bit         sec;
    bit         leap;
    logic [5:0] e_hh;
    logic [6:0] e_mm;
    logic [6:0] e_ss;
    bit         e_min;
    bit         e_day;
    bit         e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int pre, bit r, bit l, logic [5:0] h, logic [6:0] m,
                              bit s, bit lp, logic [5:0] eh, logic [6:0] em,
                              logic [6:0] es, bit emi, bit edi, bit ee);
    vec_t v;
    v.pre = pre; v.rst = r; v.load = l; v.hh = h; v.mm = m; v.sec = s; v.leap = lp;
    v.e_hh = eh; v.e_mm = em; v.e_ss = es; v.e_min = emi; v.e_day = edi; v.e_err = ee;
    return v;
  endfunction

  // One clock: inputs driven at the falling edge, outputs sampled 1 time unit after the rise.
  task automatic step(input bit r, input bit l, input logic [5:0] h, input logic [6:0] m,
                      input bit s, input bit lp);
    @(negedge clk);
    rst_n            = r;
    bus.load_i       = l;
    bus.load_hh_i    = h;
    bus.load_mm_i    = m;
    bus.second_inc_i = s;
    bus.leap_sec_i   = lp;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] eh, input logic [6:0] em,
                       input logic [6:0] es, input bit emi, input bit edi, input bit ee);
    logic [22:0] act, exp;
    act = {bus.hours_o, bus.minutes_o, bus.seconds_o,
           bus.minute_inc_o, bus.day_inc_o, bus.load_err_o};
    exp = {eh, em, es, emi, edi, ee};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h:%h:%h min=%b day=%b err=%b, want %h:%h:%h min=%b day=%b err=%b",
               name, bus.hours_o, bus.minutes_o, bus.seconds_o, bus.minute_inc_o,
               bus.day_inc_o, bus.load_err_o, eh, em, es, emi, edi, ee);
    end
  endtask

  initial begin
    int min_pulses;
    bus.load_i = 1'b0; bus.load_hh_i = 6'h00; bus.load_mm_i = 7'h00;
    bus.second_inc_i = 1'b0; bus.leap_sec_i = 1'b0;

    step(1'b0, 1'b0, 6'h00, 7'h00, 1'b0, 1'b0);
    check("reset", 6'h00, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0);

    // 61 seconds from reset: one minute rollover at the 60th strobe.
    min_pulses = 0;
    for (int i = 1; i <= 61; i++) begin
      step(1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b0);
      if (bus.minute_inc_o) min_pulses++;
      if (i == 59) check("sec59", 6'h00, 7'h00, 7'h59, 1'b0, 1'b0, 1'b0);
      if (i == 60) check("sec60", 6'h00, 7'h01, 7'h00, 1'b1, 1'b0, 1'b0);
      if (i == 61) check("sec61", 6'h00, 7'h01, 7'h01, 1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (min_pulses != 1) begin
      n_errors++;
      $display("FAIL min_pulse_count: got %0d want 1", min_pulses);
    end

    // Day rollover from 23:59.
    step(1'b1, 1'b1, 6'h23, 7'h59, 1'b0, 1'b0);
    check("load2359", 6'h23, 7'h59, 7'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b0);
      if (i == 59) check("day59", 6'h23, 7'h59, 7'h59, 1'b0, 1'b0, 1'b0);
      if (i == 60) check("day_roll", 6'h00, 7'h00, 7'h00, 1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 6'h00, 7'h00, 1'b0, 1'b0);
    check("day_strobe_end", 6'h00, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0);

    // pre, rst, load, hh, mm, sec, leap -> hh, mm, ss, min, day, err
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h09, 7'h59, 1'b0, 1'b0, 6'h09, 7'h59, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(59, 1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b0, 6'h10, 7'h00, 7'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h19, 7'h59, 1'b0, 1'b0, 6'h19, 7'h59, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(59, 1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b0, 6'h20, 7'h00, 7'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h12, 7'h34, 1'b0, 1'b0, 6'h12, 7'h34, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(59, 1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b1, 6'h12, 7'h34, 7'h60, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b1, 6'h12, 7'h35, 7'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h12, 7'h34, 1'b0, 1'b0, 6'h12, 7'h34, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(59, 1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b0, 6'h12, 7'h35, 7'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b1, 6'h12, 7'h35, 7'h01, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h24, 7'h00, 1'b0, 1'b0, 6'h12, 7'h35, 7'h01, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(0,  1'b1, 1'b0, 6'h00, 7'h00, 1'b0, 1'b0, 6'h12, 7'h35, 7'h01, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h24, 7'h00, 1'b1, 1'b0, 6'h12, 7'h35, 7'h02, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h1A, 7'h00, 1'b1, 1'b0, 6'h12, 7'h35, 7'h03, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h12, 7'h60, 1'b1, 1'b0, 6'h12, 7'h35, 7'h04, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(0,  1'b1, 1'b0, 6'h00, 7'h00, 1'b0, 1'b0, 6'h12, 7'h35, 7'h04, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h05, 7'h0A, 1'b0, 1'b0, 6'h12, 7'h35, 7'h04, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(55, 1'b1, 1'b1, 6'h08, 7'h15, 1'b1, 1'b0, 6'h08, 7'h15, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b1, 6'h23, 7'h59, 1'b0, 1'b0, 6'h23, 7'h59, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b0, 1'b1, 6'h08, 7'h15, 1'b1, 1'b0, 6'h00, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(0,  1'b1, 1'b0, 6'h00, 7'h00, 1'b0, 1'b0, 6'h00, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].pre; k++)
        step(1'b1, 1'b0, 6'h00, 7'h00, 1'b1, 1'b0);
      step(vecs[i].rst, vecs[i].load, vecs[i].hh, vecs[i].mm, vecs[i].sec, vecs[i].leap);
      check($sformatf("vec%0d", i), vecs[i].e_hh, vecs[i].e_mm, vecs[i].e_ss,
            vecs[i].e_min, vecs[i].e_day, vecs[i].e_err);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
